// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD command engine.
//   - SPI SD controller register addresses (ADDR[4:1])
//   - STATUS register bit indices
//   - engine state enum, bus request struct, frame byte helper
package sd_pkg;

  localparam logic [3:0] REG_CLKDIV     = 4'd0;
  localparam logic [3:0] REG_SLAVE_SEL  = 4'd1;
  localparam logic [3:0] REG_CTRL       = 4'd2;
  localparam logic [3:0] REG_STATUS     = 4'd3;
  localparam logic [3:0] REG_SHIFT_CTRL = 4'd4;
  localparam logic [3:0] REG_INTEN      = 4'd5;
  localparam logic [3:0] REG_INTSTAT    = 4'd6;
  localparam logic [3:0] REG_INTACT     = 4'd7;
  localparam logic [3:0] REG_DATA       = 4'd8;

  localparam int STAT_RX_EMPTY = 0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT_BUS, ST_SEL, ST_SHCTRL, ST_TX,
    ST_FILL, ST_RXSTAT, ST_RXDATA, ST_DONE
  } eng_state_e;

  typedef struct packed {
    logic        rw;     // 1 = read (68k convention)
    logic        uds_n;
    logic        lds_n;
    logic [3:0]  addr;
    logic [15:0] wdata;
  } bus_req_t;

  function automatic bus_req_t mk_req(input logic rw, input logic uds_n,
                                      input logic lds_n, input logic [3:0] addr,
                                      input logic [15:0] wdata);
    bus_req_t r;
    r.rw = rw; r.uds_n = uds_n; r.lds_n = lds_n; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  // Byte n (0..5) of the 48-bit SD command frame.
  function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic [31:0] arg,
                                            input logic [6:0] crc, input logic [2:0] n);
    logic [7:0] b;
    case (n)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      default: b = {crc, 1'b1};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_bus_port.sv
// sd_bus_port: runs one timed register access toward the SD controller.
//   req/req_bits : sequencer request, held level while the sequencer wants an access
//   ack          : pulses on the last strobe cycle; rd_byte/rd_empty are valid with it
//   acc/bus      : registered strobe and address/control/data toward the controller
//   sd_rdata     : controller read data
// An access is ACC_CYCLES of strobe followed by GAP_CYCLES idle. Because ack
// fires on the last strobe cycle, the sequencer's next request is already
// present when the gap ends, so back-to-back accesses have exactly GAP_CYCLES idle.
module sd_bus_port import sd_pkg::*; #(
  parameter int ACC_CYCLES = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic        CLKCPU,
  input  logic        RESET_n,
  input  logic        req,
  input  bus_req_t    req_bits,
  output logic        ack,
  output logic [7:0]  rd_byte,
  output logic        rd_empty,
  output logic        acc,
  output bus_req_t    bus,
  input  logic [15:0] sd_rdata
);

  typedef enum logic [1:0] {P_IDLE, P_ACC, P_GAP} ph_e;

  ph_e        ph_q, ph_d;
  logic [7:0] cnt_q, cnt_d;
  bus_req_t   bus_q, bus_d;

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q;
    bus_d = bus_q;
    ack   = 1'b0;
    unique case (ph_q)
      P_IDLE: if (req) begin ph_d = P_ACC; cnt_d = '0; bus_d = req_bits; end
      P_ACC: begin
        if (cnt_q == 8'(ACC_CYCLES-1)) begin ack = 1'b1; ph_d = P_GAP; cnt_d = '0; end
        else cnt_d = cnt_q + 8'd1;
      end
      P_GAP: begin
        if (cnt_q == 8'(GAP_CYCLES-1)) begin
          cnt_d = '0;
          if (req) begin ph_d = P_ACC; bus_d = req_bits; end
          else ph_d = P_IDLE;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: ph_d = P_IDLE;
    endcase
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      ph_q  <= P_IDLE;
      cnt_q <= '0;
      bus_q <= mk_req(1'b1, 1'b1, 1'b1, 4'd0, 16'h0000);
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      bus_q <= bus_d;
    end
  end

  assign acc      = (ph_q == P_ACC);
  assign bus      = bus_q;
  // Read data is consumed by the sequencer in the ack cycle (last strobe cycle).
  assign rd_byte  = sd_rdata[15:8];
  assign rd_empty = sd_rdata[STAT_RX_EMPTY];

  // Low byte carries nothing the engine needs beyond the rx-empty flag.
  logic unused_rd;
  assign unused_rd = ^sd_rdata[7:1];

endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD command sequencer and register-port arbiter.
//   cmd_*  : start/index/arg/crc in; busy/done/r1/timeout out
//   cpu_*  : 68k bus request toward the controller (default owner)
//   sd_*   : controller register port
// Sends a 6-byte frame plus NCR_BYTES of 0xFF, drains one RX byte per TX byte
// and captures the first post-frame byte with bit7 clear as R1.
module sd_cmd_engine import sd_pkg::*; #(
  parameter int ACC_CYCLES    = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int NCR_BYTES     = 8,
  parameter int STAT_POLL_MAX = 1023
) (
  input  logic        CLKCPU,
  input  logic        RESET_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [7:0]  cmd_r1,
  output logic        cmd_timeout,
  input  logic        cpu_access,
  input  logic        cpu_RW,
  input  logic        cpu_UDS_n,
  input  logic        cpu_LDS_n,
  input  logic [3:0]  cpu_ADDR,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_dtack_n,
  output logic        sd_access,
  output logic        sd_RW,
  output logic        sd_UDS_n,
  output logic        sd_LDS_n,
  output logic [3:0]  sd_ADDR,
  output logic [15:0] sd_wdata,
  input  logic [15:0] sd_rdata,
  input  logic        sd_dtack_n
);

  localparam int RX_BYTES = 6 + NCR_BYTES;
  localparam int PW       = $clog2(STAT_POLL_MAX + 1);

  eng_state_e    st_q, st_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic [6:0]    crc_q, crc_d;
  logic [7:0]    r1_q, r1_d;
  logic          to_q, to_d;
  logic          grant_q, grant_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;

  logic     req, ack, rd_empty, eng_acc;
  logic [7:0] rd_byte;
  bus_req_t rq, eng_bus;

  sd_bus_port #(.ACC_CYCLES(ACC_CYCLES), .GAP_CYCLES(GAP_CYCLES)) u_port (
    .CLKCPU(CLKCPU), .RESET_n(RESET_n), .req(req), .req_bits(rq), .ack(ack),
    .rd_byte(rd_byte), .rd_empty(rd_empty), .acc(eng_acc), .bus(eng_bus),
    .sd_rdata(sd_rdata)
  );

  // r1_q is preset to 0xFF on start, so r1_q[7]=1 means "no R1 captured yet".
  always_comb begin
    st_d = st_q; idx_d = idx_q; arg_d = arg_q; crc_d = crc_q;
    r1_d = r1_q; to_d = to_q; grant_d = grant_q; cnt_d = cnt_q; poll_d = poll_q;
    req  = 1'b0;
    rq   = mk_req(1'b1, 1'b1, 1'b1, 4'd0, 16'h0000);
    unique case (st_q)
      ST_IDLE: if (cmd_start) begin
        idx_d = cmd_index; arg_d = cmd_arg; crc_d = cmd_crc;
        r1_d = 8'hFF; to_d = 1'b0; st_d = ST_WAIT_BUS;
      end
      ST_WAIT_BUS: if (!cpu_access) begin grant_d = 1'b1; st_d = ST_SEL; end
      ST_SEL: begin
        req = 1'b1;
        rq  = mk_req(1'b0, 1'b0, 1'b0, REG_SLAVE_SEL, 16'h0001);
        if (ack) st_d = ST_SHCTRL;
      end
      ST_SHCTRL: begin
        req = 1'b1;
        rq  = mk_req(1'b0, 1'b0, 1'b0, REG_SHIFT_CTRL, {3'b000, 13'(RX_BYTES)});
        if (ack) begin cnt_d = '0; st_d = ST_TX; end
      end
      ST_TX: begin
        req = 1'b1;
        rq  = mk_req(1'b0, 1'b0, 1'b1, REG_DATA,
                     {frame_byte(idx_q, arg_q, crc_q, cnt_q[2:0]), 8'h00});
        if (ack) begin
          if (cnt_q == 5'd5) begin cnt_d = '0; st_d = ST_FILL; end
          else cnt_d = cnt_q + 5'd1;
        end
      end
      ST_FILL: begin
        req = 1'b1;
        rq  = mk_req(1'b0, 1'b0, 1'b1, REG_DATA, 16'hFF00);
        if (ack) begin
          if (cnt_q == 5'(NCR_BYTES-1)) begin cnt_d = '0; poll_d = '0; st_d = ST_RXSTAT; end
          else cnt_d = cnt_q + 5'd1;
        end
      end
      ST_RXSTAT: begin
        req = 1'b1;
        rq  = mk_req(1'b1, 1'b0, 1'b0, REG_STATUS, 16'h0000);
        if (ack) begin
          if (!rd_empty) begin poll_d = '0; st_d = ST_RXDATA; end
          else if (poll_q == PW'(STAT_POLL_MAX-1)) begin
            r1_d = 8'hFF; to_d = 1'b1; st_d = ST_DONE;
          end else poll_d = poll_q + 1'b1;
        end
      end
      ST_RXDATA: begin
        req = 1'b1;
        rq  = mk_req(1'b1, 1'b0, 1'b1, REG_DATA, 16'h0000);
        if (ack) begin
          // Frame-time echo bytes (first 6) never count as R1.
          if (cnt_q >= 5'd6 && r1_q[7] && !rd_byte[7]) r1_d = rd_byte;
          if (cnt_q == 5'(RX_BYTES-1)) begin to_d = r1_d[7]; st_d = ST_DONE; end
          else begin cnt_d = cnt_q + 5'd1; st_d = ST_RXSTAT; end
        end
      end
      ST_DONE: begin grant_d = 1'b0; st_d = ST_IDLE; end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      st_q <= ST_IDLE; idx_q <= '0; arg_q <= '0; crc_q <= '0;
      r1_q <= 8'hFF; to_q <= 1'b0; grant_q <= 1'b0; cnt_q <= '0; poll_q <= '0;
    end else begin
      st_q <= st_d; idx_q <= idx_d; arg_q <= arg_d; crc_q <= crc_d;
      r1_q <= r1_d; to_q <= to_d; grant_q <= grant_d; cnt_q <= cnt_d; poll_q <= poll_d;
    end
  end

  assign cmd_busy    = (st_q != ST_IDLE) && (st_q != ST_DONE);
  assign cmd_done    = (st_q == ST_DONE);
  assign cmd_r1      = r1_q;
  assign cmd_timeout = to_q;

  // Reset gates the strobe combinationally so nothing reaches the controller
  // while RESET_n is low, even with a CPU request pending.
  assign sd_access   = RESET_n & (grant_q ? eng_acc : cpu_access);
  assign sd_RW       = grant_q ? eng_bus.rw    : cpu_RW;
  assign sd_UDS_n    = grant_q ? eng_bus.uds_n : cpu_UDS_n;
  assign sd_LDS_n    = grant_q ? eng_bus.lds_n : cpu_LDS_n;
  assign sd_ADDR     = grant_q ? eng_bus.addr  : cpu_ADDR;
  assign sd_wdata    = grant_q ? eng_bus.wdata : cpu_wdata;
  assign cpu_dtack_n = grant_q ? 1'b1          : sd_dtack_n;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: controller model + write scoreboard + vector table.
module tb_sd_cmd_engine;

  logic        CLKCPU = 1'b0;
  logic        RESET_n;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        cmd_busy, cmd_done, cmd_timeout;
  logic [7:0]  cmd_r1;
  logic        cpu_access, cpu_RW, cpu_UDS_n, cpu_LDS_n;
  logic [3:0]  cpu_ADDR;
  logic [15:0] cpu_wdata;
  logic        cpu_dtack_n;
  logic        sd_access, sd_RW, sd_UDS_n, sd_LDS_n;
  logic [3:0]  sd_ADDR;
  logic [15:0] sd_wdata;
  logic [15:0] sd_rdata;
  logic        sd_dtack_n;

  always #5 CLKCPU = ~CLKCPU;

  sd_cmd_engine dut (
    .CLKCPU(CLKCPU), .RESET_n(RESET_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .cmd_r1(cmd_r1), .cmd_timeout(cmd_timeout), .cpu_access(cpu_access), .cpu_RW(cpu_RW),
    .cpu_UDS_n(cpu_UDS_n), .cpu_LDS_n(cpu_LDS_n), .cpu_ADDR(cpu_ADDR), .cpu_wdata(cpu_wdata),
    .cpu_dtack_n(cpu_dtack_n), .sd_access(sd_access), .sd_RW(sd_RW), .sd_UDS_n(sd_UDS_n),
    .sd_LDS_n(sd_LDS_n), .sd_ADDR(sd_ADDR), .sd_wdata(sd_wdata), .sd_rdata(sd_rdata),
    .sd_dtack_n(sd_dtack_n)
  );

  typedef struct {
    logic [5:0] idx; logic [31:0] arg; logic [6:0] crc;
    int r1pos; logic [7:0] r1val; int echo0; bit stuck;
    logic [7:0] exp_r1; bit exp_to; int exp_dr; int exp_sr;
  } vec_t;

  typedef struct { logic [3:0] addr; logic uds_n; logic lds_n; logic [15:0] wdata; } wr_t;

  wr_t exp_q[$];
  int total = 0, bad = 0;

  // controller model state
  int m_r1pos, m_echo0; logic [7:0] m_r1val; bit m_stuck;
  int rx_i, sreads, dreads, wr_cnt, eng_acc_cnt, done_cnt = 0, stat_empty_left, hi_cnt;
  bit prev_acc = 0, cur_eng = 0, len_chk_en = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] resp_byte(input int i);
    if (i < 6) return (i == m_echo0) ? 8'h00 : 8'hFF;
    if (i - 6 == m_r1pos) return m_r1val;
    if (i - 6 > m_r1pos) return 8'h3C;  // later valid-looking byte must be ignored
    return 8'hFF;
  endfunction

  // Controller model + monitor. Address 0xF is used only by the bench's CPU.
  always @(negedge CLKCPU) begin
    if (sd_access && !prev_acc && sd_ADDR != 4'hF) begin
      cur_eng = 1; hi_cnt = 0; eng_acc_cnt++;
      if (!sd_RW) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("wr_unexpected", 32'(exp_q.size()), 1);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr", {sd_ADDR, sd_UDS_n, sd_LDS_n, sd_wdata}, {e.addr, e.uds_n, e.lds_n, e.wdata});
        end
      end else if (sd_ADDR == 4'd3) begin
        sreads++;
        if (m_stuck || stat_empty_left > 0) begin
          sd_rdata = 16'h0001;
          if (stat_empty_left > 0) stat_empty_left--;
        end else sd_rdata = 16'hFFFE;
      end else if (sd_ADDR == 4'd8) begin
        dreads++;
        chk("rd_ds", {sd_UDS_n, sd_LDS_n}, 2'b01);
        sd_rdata = {resp_byte(rx_i), 8'h81};
        rx_i++;
        stat_empty_left = 1;
      end else chk("rd_addr", sd_ADDR, 8);
    end
    if (sd_access) hi_cnt++;
    if (!sd_access && prev_acc && cur_eng) begin
      if (len_chk_en) chk("acc_len", hi_cnt, 4);
      cur_eng = 0;
    end
    prev_acc = sd_access;
    if (cmd_done) done_cnt++;
  end

  task automatic m_setup(input vec_t v);
    logic [7:0] fb[6];
    m_r1pos = v.r1pos; m_r1val = v.r1val; m_echo0 = v.echo0; m_stuck = v.stuck;
    rx_i = 0; sreads = 0; dreads = 0; wr_cnt = 0; eng_acc_cnt = 0; stat_empty_left = 1;
    exp_q.delete();
    fb[0] = {2'b01, v.idx}; fb[1] = v.arg[31:24]; fb[2] = v.arg[23:16];
    fb[3] = v.arg[15:8];   fb[4] = v.arg[7:0];    fb[5] = {v.crc, 1'b1};
    exp_q.push_back('{4'd1, 1'b0, 1'b0, 16'h0001});
    exp_q.push_back('{4'd4, 1'b0, 1'b0, 16'h000E});
    for (int i = 0; i < 6; i++) exp_q.push_back('{4'd8, 1'b0, 1'b1, {fb[i], 8'h00}});
    for (int i = 0; i < 8; i++) exp_q.push_back('{4'd8, 1'b0, 1'b1, 16'hFF00});
  endtask

  task automatic pulse_start(input vec_t v);
    @(posedge CLKCPU); #1;
    cmd_index = v.idx; cmd_arg = v.arg; cmd_crc = v.crc; cmd_start = 1'b1;
    @(posedge CLKCPU); #1;
    cmd_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d0, n; bit got;
    m_setup(v);
    d0 = done_cnt;
    pulse_start(v);
    @(negedge CLKCPU);
    chk({tag, "_busy_rise"}, cmd_busy, 1);
    got = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge CLKCPU);
      if (cmd_done) begin got = 1; break; end
    end
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      chk({tag, "_busy_at_done"}, cmd_busy, 0);
      chk({tag, "_r1"}, cmd_r1, v.exp_r1);
      chk({tag, "_timeout"}, cmd_timeout, v.exp_to);
      chk({tag, "_data_reads"}, dreads, v.exp_dr);
      chk({tag, "_stat_reads"}, sreads, v.exp_sr);
      chk({tag, "_writes_left"}, exp_q.size(), 0);
      n = eng_acc_cnt;
      repeat (20) @(negedge CLKCPU);
      chk({tag, "_no_more_acc"}, eng_acc_cnt, n);
      chk({tag, "_one_done"}, done_cnt, d0 + 1);
      chk({tag, "_r1_held"}, cmd_r1, v.exp_r1);
    end
  endtask

  vec_t vt[6];

  initial begin
    //          idx    arg           crc    r1pos r1val  echo0 stuck exp_r1 to dr  sr
    vt[0] = '{6'd0,  32'h0,        7'h4A, 2,  8'h01, 99, 0, 8'h01, 0, 14, 28};
    vt[1] = '{6'd0,  32'h0,        7'h4A, 99, 8'hFF, 99, 0, 8'hFF, 1, 14, 28};
    vt[2] = '{6'd8,  32'h000001AA, 7'h43, 0,  8'h01, 99, 0, 8'h01, 0, 14, 28};
    vt[3] = '{6'd55, 32'h0,        7'h32, 7,  8'h05, 99, 0, 8'h05, 0, 14, 28};
    vt[4] = '{6'd0,  32'h0,        7'h4A, 99, 8'hFF, 3,  0, 8'hFF, 1, 14, 28};
    vt[5] = '{6'd0,  32'h0,        7'h4A, 99, 8'hFF, 99, 1, 8'hFF, 1, 0,  1023};

    RESET_n = 1'b0; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_crc = '0;
    cpu_access = 1'b1; cpu_RW = 1'b1; cpu_UDS_n = 1'b0; cpu_LDS_n = 1'b1;
    cpu_ADDR = 4'hF; cpu_wdata = 16'h1234; sd_dtack_n = 1'b0; sd_rdata = 16'hFFFF;

    // reset state
    repeat (3) @(negedge CLKCPU);
    chk("rst_busy", cmd_busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_r1", cmd_r1, 8'hFF);
    chk("rst_timeout", cmd_timeout, 0);
    chk("rst_sd_access", sd_access, 0);
    @(posedge CLKCPU); #1 RESET_n = 1'b1;
    @(negedge CLKCPU);
    chk("pass_access", sd_access, 1);
    chk("pass_addr", sd_ADDR, 4'hF);
    chk("pass_wdata", sd_wdata, 16'h1234);
    chk("pass_dtack", cpu_dtack_n, 0);
    @(posedge CLKCPU); #1 cpu_access = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // CPU holds the port when start arrives: engine must wait
    cpu_access = 1'b1;
    fork
      run_vec(vt[0], "cpu_hold");
      begin
        repeat (30) @(negedge CLKCPU);
        chk("cpu_hold_no_eng", eng_acc_cnt, 0);
        @(posedge CLKCPU); #1 cpu_access = 1'b0;
      end
    join

    // CPU request mid-TX: stalled until the cycle after cmd_done
    fork
      run_vec(vt[2], "cpu_mid");
      begin
        int viol; bit seen;
        viol = 0; seen = 0;
        for (int c = 0; c < 2000; c++) begin
          @(posedge CLKCPU);
          if (wr_cnt >= 4) begin seen = 1; break; end
        end
        chk("cpu_mid_tx_reached", seen, 1);
        #1 cpu_access = 1'b1;
        seen = 0;
        for (int c = 0; c < 20000; c++) begin
          @(negedge CLKCPU);
          if (cpu_dtack_n !== 1'b1) viol++;
          if (cmd_done) begin seen = 1; break; end
        end
        chk("cpu_mid_done", seen, 1);
        chk("cpu_mid_dtack_held", viol, 0);
        @(negedge CLKCPU);
        chk("cpu_mid_release_dtack", cpu_dtack_n, 0);
        chk("cpu_mid_release_addr", {sd_access, sd_ADDR}, {1'b1, 4'hF});
        @(posedge CLKCPU); #1 cpu_access = 1'b0;
      end
    join

    // asynchronous reset during TX byte index 2
    begin
      int dn; bit seen;
      m_setup(vt[0]);
      dn = done_cnt; seen = 0;
      pulse_start(vt[0]);
      for (int c = 0; c < 2000; c++) begin
        @(posedge CLKCPU);
        if (wr_cnt >= 5) begin seen = 1; break; end
      end
      chk("rst_mid_tx_reached", seen, 1);
      #2;
      chk("rst_mid_pre_access", sd_access, 1);
      len_chk_en = 0;
      RESET_n = 1'b0;
      #1;
      chk("rst_mid_access", sd_access, 0);
      chk("rst_mid_busy", cmd_busy, 0);
      repeat (4) @(negedge CLKCPU);
      @(posedge CLKCPU); #1 RESET_n = 1'b1;
      repeat (4) @(negedge CLKCPU);
      chk("rst_mid_no_done", done_cnt, dn);
      chk("rst_mid_idle", {cmd_busy, sd_access}, 2'b00);
      len_chk_en = 1;
    end
    run_vec(vt[2], "after_rst_cmd8");

    // start pulse while busy must be ignored
    fork
      run_vec(vt[3], "start_busy");
      begin
        repeat (10) @(posedge CLKCPU);
        #1 cmd_index = 6'd17; cmd_arg = 32'hDEADBEEF; cmd_crc = 7'h11; cmd_start = 1'b1;
        @(posedge CLKCPU); #1 cmd_start = 1'b0;
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Hardware SD command sequencer and bus arbiter in front of the SPI SD card controller's register port. On a start request it issues a 6-byte SD command frame through the controller and collects the R1 response. It then reports completion, so firmware no longer bit-bangs command frames register by register. It also shares the controller's register port between the 68k CPU and itself.

## Interface
Parameters:
- ACC_CYCLES, 4: CLKCPU cycles `sd_access` is held per register access (≥3, covers the controller's 100 MHz strobe sync).
- GAP_CYCLES, 2: idle CLKCPU cycles between consecutive engine accesses (≥1).
- NCR_BYTES, 8: 0xFF filler bytes clocked after the frame to poll for R1. 6+NCR_BYTES ≤ 24.
- STAT_POLL_MAX, 1023: status reads allowed per RX byte before timeout.

Ports (clock and reset first):
- CLKCPU  in  1  CPU clock.
- RESET_n  in  1  reset, asynchronous, active-low.
- cmd_start  in  1  one-cycle start pulse; ignored while busy.
- cmd_index  in  6  SD command index.
- cmd_arg  in  32  command argument.
- cmd_crc  in  7  CRC7 of frame.
- cmd_busy  out  1  engine owns or waits for the port.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_r1  out  8  R1 response (0xFF on timeout).
- cmd_timeout  out  1  no R1 or status stall.
- cpu_access, cpu_RW, cpu_UDS_n, cpu_LDS_n  in  1 each  CPU bus request.
- cpu_ADDR  in  4  CPU ADDR[4:1].
- cpu_wdata  in  16  CPU write data.
- cpu_dtack_n  out  1  CPU acknowledge.
- sd_access, sd_RW, sd_UDS_n, sd_LDS_n  out  1 each  to the controller.
- sd_ADDR  out  4  to the controller ADDR[4:1].
- sd_wdata  out  16  to the controller data_in.
- sd_rdata  in  16  controller data_out.
- sd_dtack_n  in  1  controller acknowledge.

## Operation
- Grant: CPU by default, with `sd_*` = `cpu_*` passthrough and `cpu_dtack_n` = `sd_dtack_n`. The engine takes the grant only in a cycle where `cpu_access` = 0, and returns it after DONE. While the engine holds the grant, `cpu_dtack_n` = 1 and CPU signals are not forwarded.
- Start: `cmd_start` in IDLE latches index, arg and crc, and the engine enters WAIT_BUS.
- States and actions:
  - IDLE.
  - WAIT_BUS.
  - SEL: write SLAVE_SEL (addr 1) = 0x0001.
  - SHCTRL: write SHIFT_CTRL (addr 4) = {2'b00, 1'b0, 13'(6+NCR_BYTES)}.
  - TX: 6 byte writes to addr 8 with UDS_n=0, LDS_n=1, data[15:8]. Frame bytes are {2'b01,idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc,1}.
  - FILL: NCR_BYTES byte writes of 0xFF.
  - RXSTAT: read STATUS (addr 3) and repeat until bit0 (rx_cb_empty) = 0.
  - RXDATA: byte read at addr 8, byte taken from rdata[15:8].
  - DONE.
- RX rule:
  - RXSTAT and RXDATA alternate once per transmitted byte, 6+NCR_BYTES times.
  - The first 6 bytes are discarded.
  - The first later byte with bit7 = 0 is captured as `cmd_r1`. Remaining bytes are still drained and ignored.
- Timeout is set in either of two cases:
  - No byte with bit7 = 0 is received: `cmd_r1` = 0xFF.
  - STAT_POLL_MAX consecutive empty status reads occur: abort straight to DONE, `cmd_r1` = 0xFF.
- Slave select is left asserted after DONE. Deasserting it is a firmware job.

## Timing
- Reset values: `cmd_busy` 0, `cmd_done` 0, `cmd_r1` 0xFF, `cmd_timeout` 0, grant = CPU, `sd_access` 0 while in reset.
- `cmd_busy` rises the cycle after an accepted start. It falls in the same cycle `cmd_done` pulses.
- `cmd_r1` and `cmd_timeout` are valid with `cmd_done` and held until the next accepted start, which clears `cmd_timeout`.
- Each engine access:
  - ACC_CYCLES cycles with `sd_access` = 1 and address, RW, DS and wdata stable from the first cycle.
  - Read data is sampled on the last cycle.
  - Then GAP_CYCLES cycles with `sd_access` = 0.
  - `sd_dtack_n` is not waited on.
- Grant switch to engine: one cycle after `cpu_access` is seen low; the first access starts the following cycle.
- A CPU access arriving mid-sequence stalls, with `cpu_dtack_n` = 1, until the cycle after DONE.
- Asynchronous reset mid-sequence: immediately IDLE, `sd_access` 0, grant = CPU, no `cmd_done`.

## Structure
- Package `sd_pkg`:
  - Controller register addresses (CLKDIV 0 … INTACT 7, DATA 8).
  - STATUS bit indices.
  - Engine state enum.
- Sub-module `sd_bus_port`:
  - Runs one timed access (ACC_CYCLES/GAP_CYCLES counter, read sampling) with a req/ack handshake to the sequencer FSM.
  - Arbitration mux and sequencer stay in `sd_cmd_engine`.

## Test plan
- CMD0 with arg 0, crc 0x4A, NCR_BYTES 8. The controller model returns 0x01 at poll byte 2. Expect:
  - writes 0x0001 to addr 1, then 0x000E to addr 4;
  - byte writes 40 00 00 00 00 95, then 8×FF;
  - 14 data reads;
  - `cmd_r1` = 0x01, `cmd_timeout` = 0, one `cmd_done`.
- Model returns only 0xFF → `cmd_r1` = 0xFF, `cmd_timeout` = 1, exactly 14 data reads.
- STATUS stuck empty → after 1023 status reads `cmd_timeout` = 1 and DONE; no further reads.
- `cpu_access` high at start → no engine access until CPU drops access. A CPU access mid-TX → `cpu_dtack_n` held 1 until the cycle after `cmd_done`, then passthrough.
- RESET_n low during TX byte 3 → `sd_access` 0 and `cmd_busy` 0 immediately, no `cmd_done`. A new start afterward completes a normal CMD8 (arg 0x1AA, crc 0x43, R1 0x01).
- `cmd_start` while busy → ignored; the latched frame is unchanged and a single `cmd_done` occurs.
